// File: rtl/ads127_fsync_rx.sv
// ads127_fsync_rx: frame-synchronised serial receiver for ADS127-style ADCs.
// Oversamples sck/fsync/dout in the aclk domain, deserialises up to eight
// lanes per frame and streams sign-extended samples out of an AXI-Stream
// first-word-fall-through FIFO. Whole frames are dropped when space is short.
`timescale 1ns/1ps
module ads127_fsync_rx #(
    parameter int CHANNELS   = 1,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                en,
    input  logic                sck,
    input  logic                fsync,
    input  logic [CHANNELS-1:0] dout,
    output logic [31:0]         m_axis_tdata,
    output logic [2:0]          m_axis_tuser,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [6:0]          rd_cnt,
    output logic                ovf,
    output logic                frame_err,
    output logic [15:0]         drop_cnt,
    input  logic                flag_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_W);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronisers and sck rising-edge detect
    // ---------------------------------------------------------------
    logic [1:0]          sck_sync;
    logic [1:0]          fsync_sync;
    logic                sck_d;
    logic [CHANNELS-1:0] dout_s1;
    logic [CHANNELS-1:0] dout_s2;
    logic                sck_rise;
    logic                fsync_s;

    // Two-flop synchronisers plus one delay flop for sck edge detection.
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sck_sync   <= '0;
            fsync_sync <= '0;
            sck_d      <= 1'b0;
            dout_s1    <= '0;
            dout_s2    <= '0;
        end else begin
            sck_sync   <= {sck_sync[0], sck};
            fsync_sync <= {fsync_sync[0], fsync};
            sck_d      <= sck_sync[1];
            dout_s1    <= dout;
            dout_s2    <= dout_s1;
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign fsync_s  = fsync_sync[1];

    // ---------------------------------------------------------------
    // Capture FSM
    // ---------------------------------------------------------------
    state_t          state, state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic            cap;        // shift one bit into every lane
    logic            start;      // this bit is the MSB of a new frame
    logic            err;        // fsync seen inside a frame
    logic            frame_end;  // this bit is bit 0

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and capture strobes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        start     = 1'b0;
        err       = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && sck_rise && fsync_s) begin
                    cap       = 1'b1;
                    start     = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (sck_rise) begin
                    cap = 1'b1;
                    if (fsync_s) begin
                        // Resynchronise on the new frame using this very edge.
                        err   = 1'b1;
                        start = 1'b1;
                    end else if (bit_cnt == BW'(DATA_W - 1)) begin
                        frame_end = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Lane shift registers and holding buffer
    // ---------------------------------------------------------------
    // The shift register keeps DATA_W-1 bits; the final bit goes straight
    // from the synchroniser into the holding buffer. Stale bits from an
    // aborted frame are shifted out naturally, so no explicit clear is needed.
    logic [DATA_W-2:0] shreg [CHANNELS];
    logic [DATA_W-1:0] hold  [CHANNELS];
    logic              push_pend;

    // Bit counter, lane shifting and holding-buffer load.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bit_cnt   <= '0;
            push_pend <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                shreg[c] <= '0;
                hold[c]  <= '0;
            end
        end else begin
            push_pend <= frame_end;
            if (start)    bit_cnt <= BW'(1);
            else if (cap) bit_cnt <= bit_cnt + BW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                if (cap)       shreg[c] <= {shreg[c][DATA_W-3:0], dout_s2[c]};
                if (frame_end) hold[c]  <= {shreg[c], dout_s2[c]};
            end
        end
    end

    // ---------------------------------------------------------------
    // Push engine: writes one frame, channel by channel, or drops it
    // ---------------------------------------------------------------
    logic [CW-1:0]     count;
    logic [CW-1:0]     free_words;
    logic              space_ok;
    logic              push_act;
    logic [2:0]        push_ch;
    logic [2:0]        wr_ch;
    logic              wr_en;
    logic              wr_last;
    logic              drop;
    logic [DATA_W-1:0] sample;
    logic [31:0]       wr_data;

    assign free_words = CW'(FIFO_DEPTH) - count;
    assign space_ok   = free_words >= CW'(CHANNELS);
    assign drop       = push_pend & ~space_ok;
    assign wr_en      = (push_pend & space_ok) | push_act;
    assign wr_ch      = push_pend ? 3'd0 : push_ch;
    assign wr_last    = (wr_ch == 3'(CHANNELS - 1));

    // Channel sequencing after a successful first write.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            push_act <= 1'b0;
            push_ch  <= 3'd0;
        end else if (push_pend && space_ok && CHANNELS > 1) begin
            push_act <= 1'b1;
            push_ch  <= 3'd1;
        end else if (push_act) begin
            if (push_ch == 3'(CHANNELS - 1)) push_act <= 1'b0;
            else                             push_ch  <= push_ch + 3'd1;
        end
    end

    // Select the holding-buffer word for the channel being written.
    always_comb begin
        sample = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ch == 3'(c)) sample = hold[c];
        end
    end

    generate
        if (DATA_W == 32) begin : g_full
            assign wr_data = sample;
        end else begin : g_ext
            assign wr_data = {{(32 - DATA_W){sample[DATA_W-1]}}, sample};
        end
    endgenerate

    // ---------------------------------------------------------------
    // First-word-fall-through FIFO
    // ---------------------------------------------------------------
    logic [35:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [35:0]   rd_word;
    logic          rd_en;

    // Storage array: write port only.
    // NOTE: the memory has no reset; outputs are gated by tvalid instead.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {wr_ch, wr_last, wr_data};
    end

    // Pointers and fill level; pointers wrap because depth is a power of two.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_word       = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    assign rd_en         = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? rd_word[31:0]  : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid ? rd_word[32]    : 1'b0;
    assign m_axis_tuser  = m_axis_tvalid ? rd_word[35:33] : 3'd0;
    assign rd_cnt        = 7'(count);

    // ---------------------------------------------------------------
    // Sticky status flags; a set event wins over a same-cycle clear
    // ---------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (err)           frame_err <= 1'b1;
            else if (flag_clr) frame_err <= 1'b0;

            if (drop)          ovf <= 1'b1;
            else if (flag_clr) ovf <= 1'b0;

            if (drop) begin
                if (flag_clr)                   drop_cnt <= 16'd1;
                else if (drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
            end else if (flag_clr) begin
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ads127_fsync_rx.sv
// Bench for ads127_fsync_rx: three instances (1x24-bit, 4x24-bit with a
// 4-word FIFO, 2x16-bit) share one serial stimulus generator; the instance
// that sees the serial pins is chosen with sel.
`timescale 1ns/1ps
module tb_ads127_fsync_rx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic en_all  = 1'b1;

    logic        sck_bus   = 1'b0;
    logic        fsync_bus = 1'b0;
    logic [7:0]  dout_bus  = '0;
    int          sel       = 0;
    logic [31:0] frame_words [8];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Per-instance pins
    logic sck1, fs1, sck4, fs4, sck16, fs16;
    assign sck1  = sck_bus   & (sel == 1);
    assign fs1   = fsync_bus & (sel == 1);
    assign sck4  = sck_bus   & (sel == 4);
    assign fs4   = fsync_bus & (sel == 4);
    assign sck16 = sck_bus   & (sel == 16);
    assign fs16  = fsync_bus & (sel == 16);

    logic        rdy1 = 1'b1, rdy4 = 1'b1, rdy16 = 1'b1;
    logic        clr1 = 1'b0, clr4 = 1'b0, clr16 = 1'b0;
    logic [31:0] d1, d4, d16;
    logic [2:0]  u1, u4, u16;
    logic        l1, l4, l16, v1, v4, v16;
    logic [6:0]  cnt1, cnt4, cnt16;
    logic        ovf1, ovf4, ovf16, ferr1, ferr4, ferr16;
    logic [15:0] drop1, drop4, drop16;

    ads127_fsync_rx #(.CHANNELS(1), .DATA_W(24), .FIFO_DEPTH(16)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .en(en_all), .sck(sck1), .fsync(fs1),
        .dout(dout_bus[0:0]), .m_axis_tdata(d1), .m_axis_tuser(u1),
        .m_axis_tlast(l1), .m_axis_tvalid(v1), .m_axis_tready(rdy1),
        .rd_cnt(cnt1), .ovf(ovf1), .frame_err(ferr1), .drop_cnt(drop1),
        .flag_clr(clr1));

    ads127_fsync_rx #(.CHANNELS(4), .DATA_W(24), .FIFO_DEPTH(4)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn), .en(en_all), .sck(sck4), .fsync(fs4),
        .dout(dout_bus[3:0]), .m_axis_tdata(d4), .m_axis_tuser(u4),
        .m_axis_tlast(l4), .m_axis_tvalid(v4), .m_axis_tready(rdy4),
        .rd_cnt(cnt4), .ovf(ovf4), .frame_err(ferr4), .drop_cnt(drop4),
        .flag_clr(clr4));

    ads127_fsync_rx #(.CHANNELS(2), .DATA_W(16), .FIFO_DEPTH(8)) u_dut16 (
        .aclk(aclk), .aresetn(aresetn), .en(en_all), .sck(sck16), .fsync(fs16),
        .dout(dout_bus[1:0]), .m_axis_tdata(d16), .m_axis_tuser(u16),
        .m_axis_tlast(l16), .m_axis_tvalid(v16), .m_axis_tready(rdy16),
        .rd_cnt(cnt16), .ovf(ovf16), .frame_err(ferr16), .drop_cnt(drop16),
        .flag_clr(clr16));

    // Accepted words, packed as {tuser, tlast, tdata}
    logic [35:0] q1[$], q4[$], q16[$];
    int          cyc4[$];
    logic        stall16 = 1'b0;
    logic [35:0] prev16  = '0;
    logic        rand_mode = 1'b0;

    always @(negedge aclk) begin
        if (v1 && rdy1) q1.push_back({u1, l1, d1});
    end

    always @(negedge aclk) begin
        if (v4 && rdy4) begin
            q4.push_back({u4, l4, d4});
            cyc4.push_back(cyc);
        end
    end

    // Output words must not change while stalled.
    always @(negedge aclk) begin
        if (stall16 && aresetn) begin
            checks++;
            if (!(v16 && {u16, l16, d16} === prev16)) begin
                errors++;
                $display("FAIL stall_hold got v=%b %h exp %h", v16, {u16, l16, d16}, prev16);
            end
        end
        stall16 = v16 && !rdy16 && aresetn;
        prev16  = {u16, l16, d16};
        if (v16 && rdy16) q16.push_back({u16, l16, d16});
    end

    // Random back-pressure for the 16-bit instance.
    always @(posedge aclk) begin
        #1;
        if (rand_mode) rdy16 = 1'($urandom_range(0, 1));
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference sign extension by plain arithmetic.
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        longint val  = longint'(v);
        longint half = longint'(1) << (w - 1);
        if (val >= half) val = val - 2 * half;
        return 32'(val);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Sends the first nbits of frame_words MSB-first on every lane, fsync on the first bit.
    task automatic send_frame(input int width, input int nbits, input int half);
        for (int b = 0; b < nbits; b++) begin
            sck_bus   = 1'b0;
            fsync_bus = (b == 0);
            for (int l = 0; l < 8; l++) dout_bus[l] = frame_words[l][width-1-b];
            tick(half);
            sck_bus = 1'b1;
            tick(half);
        end
        sck_bus   = 1'b0;
        fsync_bus = 1'b0;
        dout_bus  = '0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(3);
        checks++;
        if ({v1, d1, u1, l1, cnt1, ovf1, ferr1, drop1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got v=%b d=%h u=%h l=%b cnt=%0d ovf=%b ferr=%b drop=%0d exp all zero",
                     v1, d1, u1, l1, cnt1, ovf1, ferr1, drop1);
        end
        checks++;
        if ({v4, cnt4, ovf4, drop4, v16, cnt16} !== '0) begin
            errors++;
            $display("FAIL reset_others got v4=%b cnt4=%0d v16=%b cnt16=%0d exp zero", v4, cnt4, v16, cnt16);
        end
        aresetn = 1'b1;
        tick(3);
    endtask

    task automatic test_sign_ext();
        logic [31:0] src [3];
        logic [31:0] exp [3];
        logic [35:0] w;
        src[0] = 32'h7FFFFF; exp[0] = 32'h007FFFFF;
        src[1] = 32'h800000; exp[1] = 32'hFF800000;
        src[2] = 32'h000001; exp[2] = 32'h00000001;
        sel = 1; rdy1 = 1'b1; q1.delete();
        for (int i = 0; i < 3; i++) begin
            frame_words[0] = src[i];
            send_frame(24, 24, 5);
            tick(12);
        end
        checks++;
        if (q1.size() != 3) begin
            errors++;
            $display("FAIL sign_ext_count got %0d exp 3", q1.size());
        end
        for (int i = 0; i < 3 && q1.size() > 0; i++) begin
            w = q1.pop_front();
            checks++;
            if (w !== {3'd0, 1'b1, exp[i]}) begin
                errors++;
                $display("FAIL sign_ext_word%0d got %h exp %h", i, w, {3'd0, 1'b1, exp[i]});
            end
        end
    endtask

    task automatic test_multi_lane();
        logic [35:0] w;
        int          c0;
        sel = 4; rdy4 = 1'b1; q4.delete(); cyc4.delete();
        for (int l = 0; l < 4; l++) frame_words[l] = 32'(l + 1);
        send_frame(24, 24, 5);
        tick(12);
        checks++;
        if (q4.size() != 4) begin
            errors++;
            $display("FAIL lanes_count got %0d exp 4", q4.size());
        end
        c0 = (cyc4.size() > 0) ? cyc4[0] : 0;
        for (int i = 0; i < 4 && q4.size() > 0; i++) begin
            w = q4.pop_front();
            checks++;
            if (w !== {3'(i), (i == 3), 32'(i + 1)}) begin
                errors++;
                $display("FAIL lanes_word%0d got %h exp %h", i, w, {3'(i), (i == 3), 32'(i + 1)});
            end
            checks++;
            if (cyc4[i] != c0 + i) begin
                errors++;
                $display("FAIL lanes_consecutive%0d got cycle %0d exp %0d", i, cyc4[i], c0 + i);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] first [4];
        logic [35:0] w;
        sel = 4; rdy4 = 1'b0; q4.delete();
        for (int l = 0; l < 4; l++) begin
            first[l]       = 32'($urandom_range(0, 24'hFFFFFF));
            frame_words[l] = first[l];
        end
        send_frame(24, 24, 5);
        tick(12);
        for (int l = 0; l < 4; l++) frame_words[l] = 32'($urandom_range(0, 24'hFFFFFF));
        send_frame(24, 24, 5);
        tick(12);
        checks++;
        if (cnt4 !== 7'd4 || ovf4 !== 1'b1 || drop4 !== 16'd1) begin
            errors++;
            $display("FAIL ovf_state got cnt=%0d ovf=%b drop=%0d exp cnt=4 ovf=1 drop=1", cnt4, ovf4, drop4);
        end
        clr4 = 1'b1;
        tick(1);
        clr4 = 1'b0;
        checks++;
        if (ovf4 !== 1'b0 || drop4 !== 16'd0 || cnt4 !== 7'd4) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b drop=%0d cnt=%0d exp ovf=0 drop=0 cnt=4", ovf4, drop4, cnt4);
        end
        rdy4 = 1'b1;
        tick(8);
        checks++;
        if (q4.size() != 4) begin
            errors++;
            $display("FAIL ovf_drain_count got %0d exp 4", q4.size());
        end
        for (int i = 0; i < 4 && q4.size() > 0; i++) begin
            w = q4.pop_front();
            checks++;
            if (w !== {3'(i), (i == 3), sext(first[i], 24)}) begin
                errors++;
                $display("FAIL ovf_word%0d got %h exp %h", i, w, {3'(i), (i == 3), sext(first[i], 24)});
            end
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] b_word;
        sel = 1; rdy1 = 1'b1; q1.delete();
        frame_words[0] = 32'($urandom_range(0, 24'hFFFFFF));
        send_frame(24, 13, 5);
        b_word = 32'($urandom_range(0, 24'hFFFFFF));
        frame_words[0] = b_word;
        send_frame(24, 24, 5);
        tick(12);
        checks++;
        if (ferr1 !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_set got %b exp 1", ferr1);
        end
        checks++;
        if (q1.size() != 1) begin
            errors++;
            $display("FAIL frame_err_count got %0d exp 1", q1.size());
        end else begin
            checks++;
            if (q1[0] !== {3'd0, 1'b1, sext(b_word, 24)}) begin
                errors++;
                $display("FAIL frame_err_word got %h exp %h", q1[0], {3'd0, 1'b1, sext(b_word, 24)});
            end
        end
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        checks++;
        if (ferr1 !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear got %b exp 0", ferr1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] z_word;
        sel = 1; rdy1 = 1'b0; q1.delete();
        frame_words[0] = 32'h123456;
        send_frame(24, 24, 5);
        tick(12);
        checks++;
        if (cnt1 !== 7'd1 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fill got cnt=%0d v=%b exp cnt=1 v=1", cnt1, v1);
        end
        frame_words[0] = 32'hABCDEF;
        send_frame(24, 10, 5);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({v1, d1, u1, l1, cnt1, ovf1, ferr1, drop1} !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b d=%h u=%h l=%b cnt=%0d exp all zero", v1, d1, u1, l1, cnt1);
        end
        tick(2);
        aresetn = 1'b1;
        tick(2);
        rdy1 = 1'b1; q1.delete();
        z_word = 32'($urandom_range(0, 24'hFFFFFF));
        frame_words[0] = z_word;
        send_frame(24, 24, 5);
        tick(12);
        checks++;
        if (q1.size() != 1 || q1[0] !== {3'd0, 1'b1, sext(z_word, 24)}) begin
            errors++;
            $display("FAIL post_reset_frame got n=%0d w=%h exp n=1 w=%h", q1.size(),
                     (q1.size() > 0) ? q1[0] : 36'd0, {3'd0, 1'b1, sext(z_word, 24)});
        end
    endtask

    task automatic test_random();
        logic [35:0] model_q[$];
        logic [35:0] w;
        logic [31:0] v;
        int          n;
        sel = 16; rdy16 = 1'b1; q16.delete();
        frame_words[0] = 32'h8001;
        frame_words[1] = 32'h7FFF;
        send_frame(16, 16, 4);
        tick(12);
        checks++;
        if (q16.size() != 2 || q16[0] !== {3'd0, 1'b0, 32'hFFFF8001} || q16[1] !== {3'd1, 1'b1, 32'h00007FFF}) begin
            errors++;
            $display("FAIL w16_directed got n=%0d w0=%h exp %h", q16.size(),
                     (q16.size() > 0) ? q16[0] : 36'd0, {3'd0, 1'b0, 32'hFFFF8001});
        end
        q16.delete();
        rand_mode = 1'b1;
        for (int f = 0; f < 300; f++) begin
            for (int ch = 0; ch < 2; ch++) begin
                v = 32'($urandom_range(0, 65535));
                frame_words[ch] = v;
                model_q.push_back({3'(ch), (ch == 1), sext(v, 16)});
            end
            send_frame(16, 16, 4);
            tick($urandom_range(0, 6));
        end
        rand_mode = 1'b0;
        rdy16 = 1'b1;
        tick(30);
        checks++;
        if (q16.size() != model_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d exp %0d", q16.size(), model_q.size());
        end
        n = (q16.size() < model_q.size()) ? q16.size() : model_q.size();
        for (int i = 0; i < n; i++) begin
            w = q16.pop_front();
            checks++;
            if (w !== model_q[i]) begin
                errors++;
                $display("FAIL random_word%0d got %h exp %h", i, w, model_q[i]);
            end
        end
        checks++;
        if (ovf16 !== 1'b0 || drop16 !== 16'd0 || ferr16 !== 1'b0) begin
            errors++;
            $display("FAIL random_flags got ovf=%b drop=%0d ferr=%b exp 0", ovf16, drop16, ferr16);
        end
    endtask

    initial begin
        test_reset();
        test_sign_ext();
        test_multi_lane();
        test_overflow();
        test_frame_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
